// File: rtl/caliptra_prim_count_sched_if.sv
// Requester-side bundle for the shared counter: per-requester req/action/value in,
// one-hot grant and illegal-action pulse back.
interface caliptra_prim_count_sched_if #(
  parameter int unsigned NumReq = 3,
  parameter int unsigned Width  = 8
);
  logic [NumReq-1:0]       req_i;
  logic [NumReq*4-1:0]     action_i;
  logic [NumReq*Width-1:0] value_i;
  logic [NumReq-1:0]       gnt_o;
  logic                    illegal_o;

  modport master (
    output req_i, action_i, value_i,
    input  gnt_o, illegal_o
  );

  modport slave (
    input  req_i, action_i, value_i,
    output gnt_o, illegal_o
  );
endinterface

// File: rtl/caliptra_prim_count_sched.sv
// Shared counter with a round-robin scheduler; one Clr/Set/Incr/Decr applied per cycle.
// The count is held as an up/down pair whose divergence raises a sticky error.
module caliptra_prim_count_sched #(
  parameter int unsigned NumReq          = 3,
  parameter int unsigned Width           = 8,
  parameter logic [3:0]  PossibleActions = 4'hF
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  caliptra_prim_count_sched_if.slave bus,
  output logic [Width-1:0]           cnt_o,
  output logic                       sat_o,
  output logic                       err_o
);

  localparam int unsigned ActW = 4;
  localparam int unsigned PtrW = (NumReq > 1) ? $clog2(NumReq) : 1;

  localparam logic [Width-1:0] MaxVal = {Width{1'b1}};
  localparam logic [PtrW-1:0]  PtrRst = PtrW'(NumReq - 1);

  localparam logic [ActW-1:0] ActClr  = 4'h1;
  localparam logic [ActW-1:0] ActSet  = 4'h2;
  localparam logic [ActW-1:0] ActIncr = 4'h4;
  localparam logic [ActW-1:0] ActDecr = 4'h8;

  logic [Width-1:0] up_q, up_d;
  logic [Width-1:0] dn_q, dn_d;
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic             sat_q, sat_d;
  logic             err_q, err_d;

  logic [NumReq-1:0] gnt_c;
  logic              grant_c;
  logic [PtrW-1:0]   win_c;
  logic [ActW-1:0]   act_c;
  logic [Width-1:0]  val_c;
  logic              legal_c;
  int unsigned       dist_c;
  int unsigned       best_c;

  logic [Width:0]    inc_sum_c;
  logic [Width:0]    chk_sum_c;

  // Round-robin pick: smallest distance from the slot after the last winner.
  always_comb begin
    grant_c = 1'b0;
    win_c   = ptr_q;
    act_c   = '0;
    val_c   = '0;
    dist_c  = 0;
    best_c  = NumReq;
    for (int unsigned i = 0; i < NumReq; i++) begin
      dist_c = (i + NumReq - 1 - 32'(ptr_q)) % NumReq;
      if (bus.req_i[i] && !rst_i && (dist_c < best_c)) begin
        best_c  = dist_c;
        grant_c = 1'b1;
        win_c   = PtrW'(i);
        act_c   = bus.action_i[ActW*i +: ActW];
        val_c   = bus.value_i[Width*i +: Width];
      end
    end
    gnt_c = grant_c ? (NumReq'(1) << win_c) : '0;
  end

  // Legal means one-hot and enabled in the action mask.
  always_comb begin
    legal_c = (act_c inside {ActClr, ActSet, ActIncr, ActDecr}) &&
              ((act_c & PossibleActions) != '0);
  end

  assign bus.gnt_o     = gnt_c;
  assign bus.illegal_o = grant_c & ~legal_c;

  assign inc_sum_c = {1'b0, up_q} + {1'b0, val_c};
  assign chk_sum_c = {1'b0, up_q} + {1'b0, dn_q};

  // Next-state: apply the granted action to both halves of the redundant pair.
  always_comb begin
    up_d  = up_q;
    dn_d  = dn_q;
    ptr_d = ptr_q;
    sat_d = sat_q;
    err_d = err_q | (chk_sum_c != {1'b0, MaxVal});
    if (grant_c) begin
      ptr_d = win_c;
      sat_d = 1'b0;
      if (legal_c) begin
        unique case (act_c)
          ActClr: begin
            up_d = '0;
            dn_d = MaxVal;
          end
          ActSet: begin
            up_d = val_c;
            dn_d = MaxVal - val_c;
          end
          ActIncr: begin
            if (inc_sum_c[Width]) begin
              up_d  = MaxVal;
              dn_d  = '0;
              sat_d = 1'b1;
            end else begin
              up_d = inc_sum_c[Width-1:0];
              dn_d = dn_q - val_c;
            end
          end
          ActDecr: begin
            if (val_c > up_q) begin
              up_d  = '0;
              dn_d  = MaxVal;
              sat_d = 1'b1;
            end else begin
              up_d = up_q - val_c;
              dn_d = dn_q + val_c;
            end
          end
          default: begin
            up_d = up_q;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      up_q  <= '0;
      dn_q  <= MaxVal;
      ptr_q <= PtrRst;
      sat_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      up_q  <= up_d;
      dn_q  <= dn_d;
      ptr_q <= ptr_d;
      sat_q <= sat_d;
      err_q <= err_d;
    end
  end

  assign cnt_o = up_q;
  assign sat_o = sat_q;
  assign err_o = err_q;

endmodule
